// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one physical memory port between the IFU (read-only fetch) and the
// LSU (load/store). Only one transaction is in flight at a time:
//   IDLE -> REQ -> WAIT -> RESP -> IDLE
// The owner gets a single-cycle response pulse. A per-transaction timeout
// turns a stuck transaction into an error response so that the core does not hang.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to arbitrate ties round-robin.
// When it is defined, the first tie goes to the IFU. When it is undefined,
// the LSU always wins a tie.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr IFU read request (ready is combinational)
//   ifu_resp_valid/rdata/resp_err IFU response pulse, held data, timeout flag
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask  LSU request
//   lsu_resp_valid/rdata/resp_err LSU response pulse (also the write ack)
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask  downstream request
//   mem_resp_valid, mem_rdata     downstream response
//   busy                          a transaction is in progress
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic               owner_lsu;
    logic [CNT_W-1:0]   cnt;
    logic               lsu_first;
    logic               grant_lsu;
    logic               accept;
    logic               idle;
    logic               tmo_hit;
    logic               got_resp;
    logic               done;
    logic [DATA_W-1:0]  done_data;

`ifdef ARB_ROUND_ROBIN_EN
    // last_lsu == 1 after reset, so the IFU takes the first tie.
    logic last_lsu;
    assign lsu_first = !last_lsu;

    always_ff @(posedge clk) begin
        if (rst)         last_lsu <= 1'b1;
        else if (accept) last_lsu <= grant_lsu;
    end
`else
    assign lsu_first = 1'b1;
`endif

    // A single requester always wins. A tie is decided by lsu_first.
    assign idle          = (state == S_IDLE) && !rst;
    assign grant_lsu     = lsu_req_valid && (lsu_first || !ifu_req_valid);
    assign lsu_req_ready = idle && grant_lsu;
    assign ifu_req_ready = idle && ifu_req_valid && !grant_lsu;
    assign accept        = lsu_req_ready || ifu_req_ready;
    assign busy          = (state != S_IDLE);

    // cnt is 0 in the first cycle after accept. The error response lands
    // TIMEOUT cycles after the accept cycle. A real response in the same
    // cycle takes precedence over the timeout.
    assign tmo_hit   = (TIMEOUT != 0) && ((int'(cnt) + 2) >= TIMEOUT);
    assign got_resp  = (state == S_WAIT) && mem_resp_valid;
    assign done      = got_resp || (((state == S_REQ) || (state == S_WAIT)) && tmo_hit);
    assign done_data = got_resp ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            owner_lsu      <= 1'b0;
            cnt            <= '0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_err   <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            lsu_rdata      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner_lsu     <= grant_lsu;
                        mem_addr      <= grant_lsu ? lsu_addr : ifu_addr;
                        mem_wen       <= grant_lsu && lsu_wen;
                        mem_wdata     <= grant_lsu ? lsu_wdata : '0;
                        mem_wmask     <= grant_lsu ? lsu_wmask : MASK_W'(0);
                        mem_req_valid <= 1'b1;
                        cnt           <= '0;
                        state         <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (TIMEOUT != 0) cnt <= cnt + 1'b1;
                    if (done) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_RESP;
                        if (owner_lsu) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_err   <= !got_resp;
                            lsu_rdata      <= done_data;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_err   <= !got_resp;
                            ifu_rdata      <= done_data;
                        end
                    end else if ((state == S_REQ) && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_RESP: begin
                    ifu_resp_valid <= 1'b0;
                    ifu_resp_err   <= 1'b0;
                    lsu_resp_valid <= 1'b0;
                    lsu_resp_err   <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// A transaction-level model predicts every output on every cycle. The model
// tracks the owner, the cycles since accept, whether the downstream handshake
// has happened, and whether this cycle is the response cycle.
// Directed scenarios add literal checks on latency, data and grant order.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 0, ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid, ifu_resp_err;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 0, lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_resp_valid, lsu_resp_err;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid, mem_req_ready = 0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid = 0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model state ----------------
    bit            m_act = 0, m_own = 0, m_hs = 0, m_rnow = 0, m_err = 0;
    bit            m_last_lsu = 1;
    int            m_t = 0;
    logic [DW-1:0] m_ifu_rd = '0, m_lsu_rd = '0;
    logic [AW-1:0] m_addr = '0;
    bit            m_wen = 0;
    logic [DW-1:0] m_wdata = '0;
    logic [MW-1:0] m_wmask = '0;

    // bookkeeping for the literal checks
    int  acc_cyc = 0, resp_cyc = 0, n_ifu_resp = 0, n_lsu_resp = 0, stall_cnt = 0;
    bit  last_err = 0, saw_wen = 0;
    logic [MW-1:0] saw_wmask = '0;
    int  grants[$];

    // compare, then advance the model with the inputs the next edge will see
    initial begin
        bit lsu_wins, gl, any;
        @(posedge clk);
        forever begin
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            lsu_wins = !m_last_lsu;
`else
            lsu_wins = 1'b1;
`endif
            gl  = lsu_req_valid && (!ifu_req_valid || lsu_wins);
            any = !m_act && !rst;
            chk("ifu_req_ready", 32'(ifu_req_ready), 32'(any && ifu_req_valid && !gl));
            chk("lsu_req_ready", 32'(lsu_req_ready), 32'(any && gl));
            chk("busy", 32'(busy), 32'(m_act));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(m_act && !m_hs && !m_rnow));
            chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(m_rnow && !m_own));
            chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_rnow && m_own));
            chk("ifu_resp_err", 32'(ifu_resp_err), 32'(m_rnow && !m_own && m_err));
            chk("lsu_resp_err", 32'(lsu_resp_err), 32'(m_rnow && m_own && m_err));
            chk("ifu_rdata", ifu_rdata, m_ifu_rd);
            chk("lsu_rdata", lsu_rdata, m_lsu_rd);
            if (m_act && !m_hs && !m_rnow) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wen", 32'(mem_wen), 32'(m_wen));
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            end

            if (ifu_req_valid && ifu_req_ready) begin acc_cyc = cyc; grants.push_back(0); end
            if (lsu_req_valid && lsu_req_ready) begin acc_cyc = cyc; grants.push_back(1); end
            if (ifu_resp_valid) begin resp_cyc = cyc; last_err = ifu_resp_err; n_ifu_resp++; end
            if (lsu_resp_valid) begin resp_cyc = cyc; last_err = lsu_resp_err; n_lsu_resp++; end
            if (mem_req_valid) begin saw_wen = mem_wen; saw_wmask = mem_wmask; end
            if (mem_req_valid && !mem_req_ready) stall_cnt++;

            if (rst) begin
                m_act = 0; m_rnow = 0; m_hs = 0; m_err = 0; m_t = 0;
                m_ifu_rd = '0; m_lsu_rd = '0; m_last_lsu = 1;
            end else if (!m_act) begin
                if (ifu_req_valid || lsu_req_valid) begin
                    m_own = gl; m_last_lsu = gl;
                    m_addr  = gl ? lsu_addr : ifu_addr;
                    m_wen   = gl && lsu_wen;
                    m_wdata = gl ? lsu_wdata : '0;
                    m_wmask = gl ? lsu_wmask : '0;
                    m_act = 1; m_t = 1; m_hs = 0;
                end
            end else if (m_rnow) begin
                m_act = 0; m_rnow = 0;
            end else begin
                if (m_hs && mem_resp_valid) begin
                    m_rnow = 1; m_err = 0;
                    if (m_own) m_lsu_rd = mem_rdata; else m_ifu_rd = mem_rdata;
                end else if (!m_hs && mem_req_ready) m_hs = 1;
                if (!m_rnow && TMO != 0 && m_t + 1 >= TMO) begin
                    m_rnow = 1; m_err = 1;
                    if (m_own) m_lsu_rd = '0; else m_ifu_rd = '0;
                end
                m_t++;
            end
        end
    end

    // ---------------- stimulus + downstream memory ----------------
    int            rdy_dly = 0, rsp_dly = 0, wcnt = 0, pend = -1;
    logic [DW-1:0] rdat = '0;

    task automatic cycle();
        bit ai, al, hs;
        @(negedge clk);
        ai = ifu_req_valid && ifu_req_ready;
        al = lsu_req_valid && lsu_req_ready;
        hs = mem_req_valid && mem_req_ready;
        @(posedge clk); #1;
        if (ai) ifu_req_valid = 0;
        if (al) lsu_req_valid = 0;
        mem_rdata = rdat;
        if (hs) pend = rsp_dly;
        if (pend == 0) begin mem_resp_valid = 1; pend = -1; end
        else begin mem_resp_valid = 0; if (pend > 0) pend--; end
        if (mem_req_valid) begin wcnt++; mem_req_ready = (wcnt > rdy_dly); end
        else begin wcnt = 0; mem_req_ready = 0; end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin cycle(); n++; end
        while ((busy || ifu_req_valid || lsu_req_valid) && n < 60);
        if (busy || ifu_req_valid || lsu_req_valid) begin
            vectors++; miscompares++;
            $display("FAIL %s: transaction did not complete, busy=%0b", nm, busy);
        end
    endtask

    function automatic int gr(input int i);
        return (grants.size() > i) ? grants[i] : 9;
    endfunction

    initial begin
        int nl;
        repeat (2) cycle();
        rst = 0;
        cycle();

        // T1: single IFU read, zero-wait memory
        rdat = 32'h0000_0413; ifu_addr = 32'h8000_0000; ifu_req_valid = 1;
        wait_idle("t1");
        chk("t1 latency", 32'(resp_cyc - acc_cyc), 32'd3);
        chk("t1 ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1 err", 32'(last_err), 32'd0);

        // T2: LSU write, IFU untouched
        rdat = 32'h1111_2222; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_req_valid = 1;
        wait_idle("t2");
        chk("t2 mem_wen", 32'(saw_wen), 32'd1);
        chk("t2 mem_wmask", 32'(saw_wmask), 32'hF);
        chk("t2 lsu_rdata", lsu_rdata, 32'h1111_2222);
        chk("t2 ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t2 ifu resp count", 32'(n_ifu_resp), 32'd1);

        // T3: two rounds of simultaneous requests
        grants.delete();
        lsu_wen = 0; lsu_wmask = 4'h0; rdat = 32'hA5A5_0001;
        ifu_addr = 32'h8000_0040; lsu_addr = 32'h8000_2000;
        ifu_req_valid = 1; lsu_req_valid = 1;
        wait_idle("t3a");
        ifu_req_valid = 1; lsu_req_valid = 1;
        wait_idle("t3b");
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3 grant0", 32'(gr(0)), 32'd0);
        chk("t3 grant1", 32'(gr(1)), 32'd1);
        chk("t3 grant2", 32'(gr(2)), 32'd0);
        chk("t3 grant3", 32'(gr(3)), 32'd1);
`else
        chk("t3 grant0", 32'(gr(0)), 32'd1);
        chk("t3 grant1", 32'(gr(1)), 32'd0);
        chk("t3 grant2", 32'(gr(2)), 32'd1);
        chk("t3 grant3", 32'(gr(3)), 32'd0);
`endif

        // T4: downstream ready held low for 5 cycles
        rdy_dly = 5; stall_cnt = 0; rdat = 32'hCAFE_F00D;
        lsu_addr = 32'h8000_3000; lsu_req_valid = 1;
        wait_idle("t4");
        chk("t4 stall cycles", 32'(stall_cnt), 32'd5);
        chk("t4 latency", 32'(resp_cyc - acc_cyc), 32'd8);
        chk("t4 err", 32'(last_err), 32'd0);
        chk("t4 lsu_rdata", lsu_rdata, 32'hCAFE_F00D);

        // T5: no response ever -> timeout
        rdy_dly = 0; rsp_dly = -1; ifu_addr = 32'h8000_0100; ifu_req_valid = 1;
        wait_idle("t5");
        chk("t5 latency", 32'(resp_cyc - acc_cyc), 32'(TMO));
        chk("t5 err", 32'(last_err), 32'd1);
        chk("t5 ifu_rdata", ifu_rdata, 32'd0);

        // T6: reset while in WAIT; the late response must be ignored
        rsp_dly = 3; rdat = 32'h7777_7777; nl = n_lsu_resp;
        lsu_addr = 32'h8000_4000; lsu_req_valid = 1;
        cycle(); cycle();
        rst = 1; cycle(); rst = 0;
        repeat (6) cycle();
        chk("t6 lsu resp after reset", 32'(n_lsu_resp - nl), 32'd0);
        chk("t6 lsu_rdata", lsu_rdata, 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);

        // T7: recovery, one-cycle downstream response delay
        rsp_dly = 1; rdat = 32'h0BAD_F00D; ifu_addr = 32'h8000_0200; ifu_req_valid = 1;
        wait_idle("t7");
        chk("t7 latency", 32'(resp_cyc - acc_cyc), 32'd4);
        chk("t7 ifu_rdata", ifu_rdata, 32'h0BAD_F00D);

        repeat (2) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
